// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the pipeline hazard unit
// Multiply/divide tracker state encoding and counter sizing.
package hazard_pkg;

  localparam int MD_LATENCY_DEF = 32;
  localparam int MD_CNT_W       = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when a load in EX writes a register the ID instruction is about to read.
  function automatic logic load_use_f(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rs,
    input logic       id_uses_rt
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = id_uses_rs && (ex_rt == id_rs);
    rt_hit = id_uses_rt && (ex_rt == id_rt);
    return ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// rtl/muldiv_tracker.sv - tracks an in-flight multiply/divide operation
// Busy for exactly LATENCY cycles after a start pulse; only a reset aborts it.
module muldiv_tracker
  import hazard_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = MD_CNT_W'(LATENCY);
        end
      end
      MD_BUSY: begin
        // A start while busy cannot occur: the top stalls any new mul/div here.
        if (cnt_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use and mul/div interlock with redirect flushing
// Pipeline control is purely combinational; only the tracker and stall counter hold state.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rs,
  input  logic              ID_uses_rt,
  input  logic              ID_muldiv,
  input  logic              ID_hilo_rd,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_rt,
  input  logic              EX_redirect,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Write,
  output logic              IDEX_Flush,
  output logic              MD_start,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              load_use;
  logic              md_hazard;
  logic              stall;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  assign load_use  = load_use_f(EX_MemRead, EX_rt, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt);
  assign md_hazard = md_busy && (ID_muldiv || ID_hilo_rd);
  // A redirect squashes the ID instruction, so its hazard no longer matters.
  assign stall     = (load_use || md_hazard) && !EX_redirect;

  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Write = 1'b1;
    IDEX_Flush = 1'b0;
    MD_start   = 1'b0;
    if (rst) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Write = 1'b0;
    end else if (EX_redirect) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (stall) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else begin
      MD_start   = ID_muldiv;
    end
  end

  muldiv_tracker #(
    .LATENCY (MD_LATENCY)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .start_i (MD_start),
    .busy_o  (md_busy)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
// Directed scenarios then random traffic against a cycle-level behavioural model.
module tb_hazard_unit;

  localparam int LAT  = 4;
  localparam int PW   = 4;
  localparam int SMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    ID_rs, ID_rt, EX_rt;
  logic          ID_uses_rs, ID_uses_rt, ID_muldiv, ID_hilo_rd;
  logic          EX_MemRead, EX_redirect;
  logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush;
  logic          MD_start, md_busy;
  logic [PW-1:0] stall_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int m_busy_left = 0;
  int m_scnt      = 0;

  hazard_unit #(
    .MD_LATENCY (LAT),
    .PERF_W     (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_uses_rs  (ID_uses_rs),
    .ID_uses_rt  (ID_uses_rt),
    .ID_muldiv   (ID_muldiv),
    .ID_hilo_rd  (ID_hilo_rd),
    .EX_MemRead  (EX_MemRead),
    .EX_rt       (EX_rt),
    .EX_redirect (EX_redirect),
    .PC_Write    (PC_Write),
    .IFID_Write  (IFID_Write),
    .IFID_Flush  (IFID_Flush),
    .IDEX_Write  (IDEX_Write),
    .IDEX_Flush  (IDEX_Flush),
    .MD_start    (MD_start),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
    ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    ID_muldiv = 1'b0; ID_hilo_rd = 1'b0;
    EX_MemRead = 1'b0; EX_redirect = 1'b0;
  endtask

  // One pipeline cycle: compare outputs against the model, then advance the model at the edge.
  task automatic step();
    logic       lu, busy, st, start;
    logic [5:0] ctl;
    if (rst) begin
      m_busy_left = 0;
      m_scnt      = 0;
    end
    #1;
    lu = EX_MemRead && (EX_rt != 0) &&
         ((ID_uses_rs && EX_rt == ID_rs) || (ID_uses_rt && EX_rt == ID_rt));
    busy  = (m_busy_left > 0);
    st    = (lu || (busy && (ID_muldiv || ID_hilo_rd))) && !EX_redirect;
    start = ID_muldiv && !st && !EX_redirect && !rst;
    if (rst)              ctl = 6'b000000;
    else if (EX_redirect) ctl = 6'b111110;
    else if (st)          ctl = 6'b000110;
    else                  ctl = {5'b11010, start};
    check("ctl", {26'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, MD_start},
          {26'd0, ctl});
    check("md_busy", {31'd0, md_busy}, {31'd0, busy});
    check("stall_cnt", {28'd0, stall_cnt}, m_scnt);
    @(posedge clk);
    if (!rst) begin
      if (st && m_scnt < SMAX) m_scnt++;
      if (start)               m_busy_left = LAT;
      else if (m_busy_left > 0) m_busy_left--;
    end
    #1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    // load-use stall then release
    EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_uses_rs = 1'b1;
    step();
    check("lu_cnt", {28'd0, stall_cnt}, 32'd1);
    EX_MemRead = 1'b0;
    step();

    // r0 never interlocks; unused source never interlocks
    EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
    step();
    EX_rt = 5'd7; ID_rt = 5'd7; ID_uses_rt = 1'b0; ID_uses_rs = 1'b0;
    step();

    // redirect beats load-use
    ID_uses_rt = 1'b1; EX_redirect = 1'b1;
    step();
    check("redir_cnt", {28'd0, stall_cnt}, 32'd1);
    clr_in();

    // mul/div then dependent mfhi
    ID_muldiv = 1'b1;
    step();
    ID_muldiv = 1'b0; ID_hilo_rd = 1'b1;
    repeat (5) step();
    clr_in();

    // back-to-back mul/div waits for busy to drop
    ID_muldiv = 1'b1;
    repeat (6) step();
    ID_muldiv = 1'b0;
    repeat (2) step();
    ID_muldiv = 1'b1; EX_redirect = 1'b1;
    step();
    clr_in();
    repeat (3) step();
    ID_muldiv = 1'b1; EX_redirect = 1'b1;
    step();
    clr_in();

    // reset in the second busy cycle
    ID_muldiv = 1'b1;
    step();
    ID_muldiv = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // counter saturation
    EX_MemRead = 1'b1; EX_rt = 5'd9; ID_rt = 5'd9; ID_uses_rt = 1'b1;
    repeat (17) step();
    check("sat", {28'd0, stall_cnt}, SMAX);
    clr_in();

    // random traffic with narrow register ranges to provoke matches
    for (int i = 0; i < 600; i++) begin
      ID_rs       = 5'($urandom_range(0, 3));
      ID_rt       = 5'($urandom_range(0, 3));
      EX_rt       = 5'($urandom_range(0, 3));
      ID_uses_rs  = 1'($urandom_range(0, 1));
      ID_uses_rt  = 1'($urandom_range(0, 1));
      ID_muldiv   = ($urandom_range(0, 3) == 0);
      ID_hilo_rd  = ($urandom_range(0, 3) == 0);
      EX_MemRead  = ($urandom_range(0, 2) == 0);
      EX_redirect = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0;
    clr_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MD_LATENCY, 32, multiply/divide busy cycles (legal 2..63).
REQ-002 Parameter PERF_W, 16, width of stall performance counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ID_rs, ID_rt  in  5 each  source register numbers of instruction in ID.
REQ-006 ID_uses_rs, ID_uses_rt  in  1 each  ID instruction reads that source.
REQ-007 ID_muldiv  in  1  ID instruction is mult/multu/div/divu.
REQ-008 ID_hilo_rd  in  1  ID instruction is mfhi/mflo.
REQ-009 EX_MemRead  in  1  load in EX (ID/EX register output).
REQ-010 EX_rt  in  5  destination of load in EX.
REQ-011 EX_redirect  in  1  taken branch, jump, jal or jr resolved in EX.
REQ-012 PC_Write, IFID_Write  out  1 each  enable PC / IF-ID register update.
REQ-013 IFID_Flush  out  1  clear IF/ID instruction.
REQ-014 IDEX_Write, IDEX_Flush  out  1 each  drive ID/EX register write and control-clear.
REQ-015 MD_start  out  1  one-cycle start pulse to multiply/divide unit.
REQ-016 md_busy  out  1  multiply/divide in progress.
REQ-017 stall_cnt  out  PERF_W  count of stall cycles since reset.

Function
REQ-018 load_use SHALL be EX_MemRead & (EX_rt!=0) & ((ID_uses_rs & EX_rt==ID_rs) | (ID_uses_rt & EX_rt==ID_rt)).
REQ-019 md_hazard SHALL be md_busy & (ID_muldiv | ID_hilo_rd).
REQ-020 stall SHALL be (load_use | md_hazard) & ~EX_redirect.
REQ-021 Redirect cycle: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Write=1, IDEX_Flush=1.
REQ-022 Stall cycle: PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Write=1, IDEX_Flush=1 (bubble).
REQ-023 Otherwise: PC_Write=1, IFID_Write=1, IDEX_Write=1, both flushes 0.
REQ-024 Redirect SHALL take priority over stall in the same cycle; no bubble counted.
REQ-025 Hazard outputs SHALL be combinational from inputs and md_busy; zero added latency.
REQ-026 MD_start=1 iff ID_muldiv & ~stall & ~EX_redirect & ~rst.
REQ-027 FSM states MD_IDLE, MD_BUSY; MD_IDLE->MD_BUSY on MD_start, loading 6-bit down-counter with MD_LATENCY.
REQ-028 In MD_BUSY counter SHALL decrement each cycle; at count==1 next state MD_IDLE, count 0.
REQ-029 md_busy=1 exactly MD_LATENCY cycles, starting the cycle after MD_start.
REQ-030 mult/div in ID during final busy cycle SHALL stall; it starts the following cycle (no back-to-back overlap).
REQ-031 EX_redirect SHALL NOT abort an in-progress MD_BUSY (older instruction).
REQ-032 stall_cnt SHALL increment by 1 on each clock edge where stall=1; saturate at all-ones.

Reset
REQ-033 rst SHALL force state MD_IDLE, counter 0, md_busy 0, stall_cnt 0 immediately.
REQ-034 While rst=1: PC_Write=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=0, IDEX_Flush=0, MD_start=0.
REQ-035 Reset mid-MD_BUSY SHALL abandon the operation; first cycle after rst deassert md_busy=0.

Structure
REQ-036 Package hazard_pkg SHALL hold MD_LATENCY default, md state encoding (MD_IDLE=0, MD_BUSY=1), counter width 6.
REQ-037 Sub-module muldiv_tracker SHALL hold FSM and down-counter; hazard/flush logic and stall_cnt in top.

Verification (MD_LATENCY=4)
REQ-038 EX_MemRead=1, EX_rt=5, ID_rs=5, ID_uses_rs=1 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1, stall_cnt +1; next cycle EX_MemRead=0 -> all enables 1.
REQ-039 EX_MemRead=1, EX_rt=0, ID_rs=0 -> no stall; EX_rt=7, ID_rt=7, ID_uses_rt=0 -> no stall.
REQ-040 Load-use and EX_redirect same cycle -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1, stall_cnt unchanged.
REQ-041 ID_muldiv pulse -> MD_start 1 cycle, md_busy high 4 cycles; ID_hilo_rd held -> stalled 4 cycles, proceeds 5th.
REQ-042 Second ID_muldiv during busy -> MD_start only after md_busy falls; ID_muldiv with EX_redirect -> no MD_start.
REQ-043 rst asserted at busy cycle 2 -> md_busy=0, stall_cnt=0 at once; 17-bit-worth of stalls with PERF_W=4 -> stall_cnt holds 15.
